// File: rtl/jetpack_pkg.sv
// Shared game types and playfield geometry for the jetpack obstacle pipeline.
package jetpack_pkg;

    typedef enum logic [1:0] {
        MENU = 2'b00,
        PLAY = 2'b01,
        OVER = 2'b10
    } game_state_e;

    typedef enum logic [1:0] {
        LASER   = 2'b00,
        MISSILE = 2'b01,
        FLICKER = 2'b10,
        COIN    = 2'b11
    } obs_type_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_GRACE,
        S_DEAD
    } fsm_state_e;

    localparam int PLAYER_W = 16;
    localparam int PLAYER_H = 24;
    localparam int OBS_W    = 20;
    localparam int BAND0    = 40;
    localparam int BAND_H   = 100;
    localparam int SCREEN_W = 640;

    // A flicker laser only hurts during its lit phase; coins never hurt.
    function automatic logic is_harmful(input logic [1:0] typ, input logic flick);
        return (typ == LASER) || (typ == MISSILE) || ((typ == FLICKER) && flick);
    endfunction

endpackage

// File: rtl/hitbox_overlap.sv
// Combinational rectangle test between one obstacle in its lane band and the player hitbox.
module hitbox_overlap
    import jetpack_pkg::*;
#(
    parameter int PLAYER_X = 100
) (
    input  logic [9:0] x,
    input  logic [1:0] pos,
    input  logic [8:0] player_y,
    output logic       overlap
);

    logic [10:0] x_w;
    logic [10:0] y_w;
    logic [10:0] top;

    // 11 bits hold every sum below (max 740+20, 479+24, 340+100) without wrap.
    always_comb begin
        x_w     = {1'b0, x};
        y_w     = {2'b00, player_y};
        top     = 11'(BAND0) + 11'(pos) * 11'(BAND_H);
        overlap = (x_w < 11'(PLAYER_X + PLAYER_W))
               && ((x_w + 11'(OBS_W)) > 11'(PLAYER_X))
               && (y_w < (top + 11'(BAND_H)))
               && ((y_w + 11'(PLAYER_H)) > top)
               && (x_w < 11'(SCREEN_W));
    end

endmodule

// File: rtl/collision_detect.sv
// Registers per-obstacle harm/coin overlap flags, then runs the life/grace FSM and coin counter.
// hit/coin pulse two cycles after the obstacle input that causes them.
module collision_detect
    import jetpack_pkg::*;
#(
    parameter int LIVES    = 3,
    parameter int INVULN   = 1000,
    parameter int PLAYER_X = 100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] game_state,
    input  logic       incr,
    input  logic [9:0] obs1_x,
    input  logic [9:0] obs2_x,
    input  logic [1:0] obs1_pos,
    input  logic [1:0] obs2_pos,
    input  logic [1:0] type1,
    input  logic [1:0] type2,
    input  logic       flick1,
    input  logic       flick2,
    input  logic [8:0] player_y,
    output logic       hit,
    output logic       coin,
    output logic [1:0] lives,
    output logic [7:0] coins,
    output logic       invuln,
    output logic       game_over
);

    localparam int CW = $clog2(INVULN + 1);

    logic ov1;
    logic ov2;

    hitbox_overlap #(.PLAYER_X(PLAYER_X)) u_ov1 (
        .x        (obs1_x),
        .pos      (obs1_pos),
        .player_y (player_y),
        .overlap  (ov1)
    );

    hitbox_overlap #(.PLAYER_X(PLAYER_X)) u_ov2 (
        .x        (obs2_x),
        .pos      (obs2_pos),
        .player_y (player_y),
        .overlap  (ov2)
    );

    logic [1:0]  harm_q, harm_d;
    logic [1:0]  cov_q, cov_d;
    logic [1:0]  cov_prev_q, cov_prev_d;
    fsm_state_e  state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic        hit_q, hit_d;
    logic        coin_q, coin_d;
    logic [1:0]  lives_q, lives_d;
    logic [7:0]  coins_q, coins_d;
    logic        invuln_q, invuln_d;
    logic        game_over_q, game_over_d;

    logic        play;
    logic [1:0]  cov_rise;
    logic [8:0]  coin_sum;

    always_comb begin
        harm_d      = {ov2 && is_harmful(type2, flick2), ov1 && is_harmful(type1, flick1)};
        cov_d       = {ov2 && (type2 == COIN), ov1 && (type1 == COIN)};
        cov_prev_d  = cov_q;
        cov_rise    = cov_q & ~cov_prev_q;
        play        = (game_state == PLAY);

        state_d     = state_q;
        cnt_d       = cnt_q;
        hit_d       = 1'b0;
        coin_d      = 1'b0;
        lives_d     = lives_q;
        coins_d     = coins_q;
        game_over_d = game_over_q;
        invuln_d    = play && (state_q == S_GRACE);
        coin_sum    = {1'b0, coins_q} + {8'd0, cov_rise[0]} + {8'd0, cov_rise[1]};

        if (!play) begin
            state_d     = S_IDLE;
            lives_d     = 2'(LIVES);
            cnt_d       = '0;
            game_over_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d     = S_ARMED;
                    lives_d     = 2'(LIVES);
                    coins_d     = 8'd0;
                    game_over_d = 1'b0;
                end
                S_ARMED: begin
                    // Two harmful obstacles in one cycle still cost a single life.
                    if (|harm_q) begin
                        hit_d   = 1'b1;
                        lives_d = lives_q - 2'd1;
                        if (lives_q == 2'd1) begin
                            state_d     = S_DEAD;
                            game_over_d = 1'b1;
                        end else begin
                            state_d = S_GRACE;
                            cnt_d   = CW'(INVULN);
                        end
                    end
                end
                S_GRACE: begin
                    if (incr) begin
                        if (cnt_q == CW'(1)) begin
                            state_d = S_ARMED;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q - CW'(1);
                        end
                    end
                end
                S_DEAD: begin
                    game_over_d = 1'b1;
                end
            endcase

            if (((state_q == S_ARMED) || (state_q == S_GRACE)) && (|cov_rise)) begin
                coin_d  = 1'b1;
                coins_d = coin_sum[8] ? 8'hFF : coin_sum[7:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            harm_q      <= '0;
            cov_q       <= '0;
            cov_prev_q  <= '0;
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            hit_q       <= 1'b0;
            coin_q      <= 1'b0;
            lives_q     <= 2'(LIVES);
            coins_q     <= 8'd0;
            invuln_q    <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            harm_q      <= harm_d;
            cov_q       <= cov_d;
            cov_prev_q  <= cov_prev_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hit_q       <= hit_d;
            coin_q      <= coin_d;
            lives_q     <= lives_d;
            coins_q     <= coins_d;
            invuln_q    <= invuln_d;
            game_over_q <= game_over_d;
        end
    end

    assign hit       = hit_q;
    assign coin      = coin_q;
    assign lives     = lives_q;
    assign coins     = coins_q;
    assign invuln    = invuln_q;
    assign game_over = game_over_q;

endmodule

// File: doc/collision_detect.md
# collision_detect

Consumer end of the obstacle stream. Samples the two obstacles' x-position, lane, type and flicker phase each cycle. Tests each against the player hitbox and runs a life/invulnerability state machine. Emits hit and coin pulses, a lives count, a coin count and a sticky game-over flag for the top-level game-state controller.

## Interface
- LIVES, 3: lives loaded on reset and on each new game.
- INVULN, 1000: grace cycles after a hit, counted on `incr` ticks.
- PLAYER_X, 100: player hitbox left edge in pixels; the hitbox is fixed horizontally.
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- game_state  in  2  00 menu, 01 play, 10 over
- incr  in  1  one-cycle obstacle step tick from the obstacle generator
- obs1_x, obs2_x  in  10  obstacle left edge, 0..740; values ≥640 are off-screen
- obs1_pos, obs2_pos  in  2  lane index 0..3
- type1, type2  in  2  00 laser, 01 missile, 10 flicker laser, 11 coin
- flick1, flick2  in  1  flicker phase; a flicker laser is harmful only when this is 1
- player_y  in  9  player hitbox top edge, 0..479
- hit  out  1  one-cycle pulse when a life is lost
- coin  out  1  one-cycle pulse per coin collected
- lives  out  2  remaining lives
- coins  out  8  coins this game, saturates at 255
- invuln  out  1  high while in GRACE
- game_over  out  1  sticky until game_state leaves 01

## Operation
- Geometry constants:
  - PLAYER_W=16, PLAYER_H=24, OBS_W=20, BAND0=40, BAND_H=100.
  - Lane band top = BAND0 + pos*BAND_H.
- Overlap test, per obstacle, computed in 11-bit unsigned arithmetic with no wrap:
  - obs_x < PLAYER_X+PLAYER_W, and
  - obs_x+OBS_W > PLAYER_X, and
  - player_y < top+BAND_H, and
  - player_y+PLAYER_H > top.
- Harmful overlap: the overlap test passes and either type ∈ {00,01}, or type=10 with flick=1.
- Coin overlap: the overlap test passes and type=11.
- Coin collection is edge-detected per obstacle: a coin counts only on the rising edge of its coin-overlap signal, so each coin pass counts once.
- FSM states and transitions:
  - IDLE: lives=LIVES. On game_state==01, go to ARMED and clear coins.
  - ARMED: on any harmful overlap, pulse hit and decrement lives. If the decremented value is 0, go to DEAD; otherwise go to GRACE and load the grace counter with INVULN.
  - GRACE: harmful overlaps are ignored. The counter decrements on each incr. Go to ARMED when incr arrives while the counter is 1.
  - DEAD: game_over=1. Hits and coins are ignored.
- Any state goes to IDLE whenever game_state≠01. This covers leaving play mid-GRACE and mid-DEAD.
- Coins count in ARMED and GRACE only.
- Simultaneous events:
  - Both obstacles harmful in the same cycle: one life lost.
  - Hit and coin in the same cycle: both take effect.
  - Two coin edges in the same cycle: coins increments by 2, saturating at 255, and coin pulses once.

## Timing
- Reset values: hit=0, coin=0, lives=LIVES, coins=0, invuln=0, game_over=0, state=IDLE, grace counter=0, edge registers=0.
- Stage 1 registers the per-obstacle harmful and coin-overlap flags. Stage 2 is the FSM and counters.
- hit and coin are asserted 2 cycles after the input change that creates the overlap.
- lives, coins and game_over update in the same cycle as the corresponding pulse.
- invuln is high in the cycle after the hit pulse, and stays high through the cycle in which the counter expires.
- reset dominates game_state.

## Structure
- jetpack_pkg holds:
  - the game_state typedef enum (MENU, PLAY, OVER);
  - the obstacle type enum (LASER, MISSILE, FLICKER, COIN);
  - the geometry constants (PLAYER_W, PLAYER_H, OBS_W, BAND0, BAND_H, SCREEN_W=640).
- One sub-module, hitbox_overlap: a combinational rectangle test taking x, pos and player_y, with PLAYER_X as a parameter. Instantiate it twice.
- FSM, grace counter, edge detect and counters live in collision_detect.

## Test plan
- Harmful hit:
  - Stimulus: reset; game_state=01; obs1_x=90, pos=1, type=00, player_y=150.
  - Response: hit pulses 2 cycles later; lives 3→2; invuln=1.
- Grace window:
  - Stimulus: INVULN=4; overlap held after the hit.
  - Response: no further hit until the 4th incr. On return to ARMED, a second hit occurs, lives=1.
- Flicker laser: type=10, flick=0 with overlap → no hit; toggling flick to 1 → hit.
- Coin:
  - Stimulus: coin overlap held for 10 cycles, then both obstacles' coin overlaps rising in the same cycle.
  - Response: the held overlap gives one coin pulse and coins=1; the simultaneous rising edges give coins=3.
- Game over:
  - Stimulus: three separated hits.
  - Response: lives=0, game_over=1, further overlaps ignored. Setting game_state=10 next gives IDLE, lives=3, game_over=0.
- Boundaries:
  - Stimulus: obs_x=116 and obs_x=80; obs_x=700.
  - Response: 116 and 80 (edge-touching) give no hit; 700 (off-screen) gives no hit. Leaving play mid-GRACE gives IDLE, invuln=0.
